pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_buf_ptr.sv | 46 ++++
 rtl/pipe_stage_buf.sv | 130 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the write-back (WB) pipeline: total bundle width and
// the bit positions of the bundle fields that other blocks pick out of it.
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Full write-back bundle width in bits.
    localparam int WB_BUS_W = 269;

    // Field positions inside the WB bundle.
    localparam int WB_VALID_LSB    = 0;
    localparam int WB_VALID_MSB    = 0;
    localparam int WB_DFLAG_LSB    = 1;
    localparam int WB_DFLAG_MSB    = 1;
    localparam int WB_SPILL_LSB    = 2;
    localparam int WB_SPILL_MSB    = 3;
    localparam int WB_CACHABLE_LSB = 268;
    localparam int WB_CACHABLE_MSB = 268;

endpackage

// File: rtl/pipe_buf_ptr.sv
// ---------------------------------------------------------------------------
// pipe_buf_ptr
// Circular buffer index: increments by one per inc pulse and wraps from
// DEPTH-1 back to 0, so it never holds an index of DEPTH or above.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (ptr -> 0)
//   clr  - synchronous clear (ptr -> 0), priority over inc
//   inc  - advance the pointer by one slot
//   ptr  - current index
// ---------------------------------------------------------------------------
module pipe_buf_ptr #(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register: reset/clear to slot 0, otherwise advance with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (clr) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            if (ptr_r == LAST_PTR) begin
                ptr_r <= {PTR_W{1'b0}};
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
// Elastic pipeline buffer of DEPTH entries of WIDTH bits with valid/ready
// handshakes on both sides and a flush (squash) input. in_ready depends only
// on the stored count, so there is no combinational path from out_ready.
// Optional feature macro: PIPE_STALL_CNT_EN enables a saturating 16-bit count
// of cycles in which upstream was stalled; otherwise stall_cnt is tied to 0.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid/in_data    - upstream bundle, accepted when in_ready = 1
//   in_ready            - buffer not full
//   out_valid/out_data  - head entry (out_data is zero while empty)
//   out_ready           - downstream consumes the head
//   flush               - discard all entries at the next edge
//   count               - occupied entries
//   stall_cnt           - saturating upstream-stall cycle count
// ---------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = WB_BUS_W,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      stall_cnt
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [WIDTH-1:0] out_data_s;
    logic [WIDTH-1:0] mem_r [DEPTH];

    assign in_ready_s  = (count_r != FULL_CNT);
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = in_valid & in_ready_s & ~flush;
    assign pop_s       = out_valid_s & out_ready & ~flush;

    pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_s),
        .ptr (rd_ptr_s)
    );

    pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_s),
        .ptr (wr_ptr_s)
    );

    // Occupancy register: rst beats flush, which beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_r <= count_r + ONE_CNT;
        end else if (pop_s && !push_s) begin
            count_r <= count_r - ONE_CNT;
        end else begin
            count_r <= count_r;
        end
    end

    // Payload storage: written only on an accepted push, never reset
    // because out_data is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_s] <= in_data;
        end
    end

    // Head read with zero masking while empty.
    always_comb begin
        out_data_s = {WIDTH{1'b0}};
        if (out_valid_s) begin
            out_data_s = mem_r[rd_ptr_s];
        end else begin
            out_data_s = {WIDTH{1'b0}};
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Stall counter: counts refused offers (not flush cycles), sticks at max.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (in_valid && !in_ready_s && !flush && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign count     = count_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
// Two buffers (DEPTH=2 and DEPTH=3) share the same stimulus; each is compared
// every cycle against a queue-based reference model of an elastic FIFO.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int W = 269;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         flush;

    logic         ir2, ov2, ir3, ov3;
    logic [W-1:0] od2, od3;
    logic [1:0]   cnt2, cnt3;
    logic [15:0]  sc2, sc3;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];
    int           st2 = 0;
    int           st3 = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
        .flush(flush), .count(cnt2), .stall_cnt(sc2)
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready),
        .flush(flush), .count(cnt3), .stall_cnt(sc3)
    );

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // Compare both DUTs against the model state (outputs depend on state only).
    task automatic check_all();
        logic [W-1:0] e2, e3;
        e2 = (q2.size() != 0) ? q2[0] : '0;
        e3 = (q3.size() != 0) ? q3[0] : '0;
        check_val("d2_in_ready",  W'(ir2),  W'(q2.size() != 2));
        check_val("d2_out_valid", W'(ov2),  W'(q2.size() != 0));
        check_val("d2_out_data",  od2,      e2);
        check_val("d2_count",     W'(cnt2), W'(q2.size()));
        check_val("d2_stall_cnt", W'(sc2),  W'(st2));
        check_val("d3_in_ready",  W'(ir3),  W'(q3.size() != 3));
        check_val("d3_out_valid", W'(ov3),  W'(q3.size() != 0));
        check_val("d3_out_data",  od3,      e3);
        check_val("d3_count",     W'(cnt3), W'(q3.size()));
        check_val("d3_stall_cnt", W'(sc3),  W'(st3));
    endtask

    // One FIFO step of the reference model for a buffer of the given depth.
    task automatic model_fifo(input int depth, inout logic [W-1:0] q[$], inout int st);
        bit can_push, can_pop;
        if (rst) begin
            q.delete();
            st = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            can_push = in_valid && (q.size() < depth);
            can_pop  = out_ready && (q.size() > 0);
`ifdef PIPE_STALL_CNT_EN
            if (in_valid && !can_push && st < 65535) st++;
`endif
            if (can_pop) void'(q.pop_front());
            if (can_push) q.push_back(in_data);
        end
    endtask

    // Drive one cycle: apply inputs, check, clock, advance the model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic r, input bit chk);
        in_valid = v; in_data = d; out_ready = ordy; flush = fl; rst = r;
        #1;
        if (chk) check_all();
        @(posedge clk);
        model_fifo(2, q2, st2);
        model_fifo(3, q3, st3);
        @(negedge clk);
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset state
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("rst_in_ready", W'(ir2), W'(1));
        check_val("rst_out_data", od2, '0);

        // Two pushes with a stalled consumer, then drain.
        cycle(1'b1, W'(1), 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, W'(2), 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("fill_count", W'(cnt2), W'(2));
        check_val("fill_in_ready", W'(ir2), W'(0));
        check_val("fill_head", od2, W'(1));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("drain_second", od2, W'(2));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("drain_count", W'(cnt2), W'(0));

        // Streaming 0..9 with both sides always ready.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
            check_val("stream_d3_head", od3, W'(i));
            check_val("stream_d3_count", W'(cnt3), W'(1));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Full buffer with push and pop offered together.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, W'(16'hA1), 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, W'(16'hA2), 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, W'(16'hA3), 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("full_pop_in_ready", W'(ir2), W'(1));
        check_val("full_pop_count", W'(cnt2), W'(1));
        check_val("full_pop_head", od2, W'(16'hA2));

        // Flush while full with a simultaneous offer.
        cycle(1'b1, W'(16'hA4), 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, W'(16'hBAD), 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("flush_count", W'(cnt2), W'(0));
        check_val("flush_out_valid", W'(ov2), W'(0));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset together with flush while holding one entry.
        cycle(1'b1, W'(16'h55), 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, W'(16'h66), 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("rst_flush_count", W'(cnt2), W'(0));
        check_val("rst_flush_data", od2, '0);
        check_val("rst_flush_stall", W'(sc2), W'(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_wide(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 199) == 0), 1'b1);
        end

        // Hold full with a persistent offer to saturate the stall counter.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 70000; i++) begin
            cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PIPE_STALL_CNT_EN
        check_val("stall_saturated", W'(sc2), W'(16'hFFFF));
`else
        check_val("stall_tied_zero", W'(sc2), W'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
